mpck_phase_decoder: RTL and testbench

- Receive-side checker for the 8-phase interleaved divider clocks.
- Samples the 8-bit phase word on the fast clock, decodes it back to the 3-bit divider count, and tracks the expected rotation with a local predictor.
- Declares lock, flags illegal words and phase slips, and counts errors.
- Sits next to the multi-phase divider as its monitor/decoder, clocked by the same fast clock that drives the divider counter.

---
 rtl/mpck_pkg.sv | 17 +
 rtl/mpck_word_dec.sv | 37 +++
 rtl/mpck_phase_decoder.sv | 152 +++++++++++++++
 tb/tb_mpck_phase_decoder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mpck_pkg.sv
// Shared definitions for the multi-phase clock receive-side decoder.
package mpck_pkg;

  localparam int unsigned NPH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  // Index = divider count c; bit k set iff (c - k) mod 8 is in 0..3
  localparam logic [NPH-1:0] LEGAL_WORD [NPH] = '{
    8'hE1, 8'hC3, 8'h87, 8'h0F, 8'h1E, 8'h3C, 8'h78, 8'hF0
  };

endpackage

// File: rtl/mpck_word_dec.sv
// Combinational phase word -> {legal, count} lookup.
module mpck_word_dec #(
  parameter int unsigned NPH = mpck_pkg::NPH,
  parameter int unsigned CW  = $clog2(NPH)
) (
  input  logic [NPH-1:0] i_word,
  output logic           o_legal,
  output logic [CW-1:0]  o_cnt
);

  logic [NPH-1:0] w_tbl [NPH];

  // Other phase counts build the half-high rotation table on the fly
  if (NPH == mpck_pkg::NPH) begin : g_pkg_tbl
    for (genvar c = 0; c < NPH; c++) begin : g_row
      assign w_tbl[c] = mpck_pkg::LEGAL_WORD[c];
    end
  end else begin : g_gen_tbl
    for (genvar c = 0; c < NPH; c++) begin : g_row
      for (genvar k = 0; k < NPH; k++) begin : g_bit
        assign w_tbl[c][k] = (((c + NPH - k) % NPH) < (NPH / 2));
      end
    end
  end

  always_comb begin
    o_legal = 1'b0;
    o_cnt   = '0;
    for (int unsigned c = 0; c < NPH; c++) begin
      if (i_word == w_tbl[c]) begin
        o_legal = 1'b1;
        o_cnt   = CW'(c);
      end
    end
  end

endmodule

// File: rtl/mpck_phase_decoder.sv
// Receive-side checker: decodes the 8-phase word, predicts rotation,
// tracks lock and counts errors.
module mpck_phase_decoder
  import mpck_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned MISS_MAX = 4,
  parameter int unsigned ERRW     = 16
) (
  input  logic            CLK,
  input  logic            NARST,
  input  logic            EN,
  input  logic [NPH-1:0]  FMP,
  input  logic            ERR_CLR,
  output logic [2:0]      CNT_REC,
  output logic            CNT_VLD,
  output logic            LOCK,
  output logic            ERR,
  output logic            SLIP,
  output logic [ERRW-1:0] ERR_CNT
);

  localparam int unsigned RW = $clog2(LOCK_CNT + 1);
  localparam int unsigned MW = $clog2(MISS_MAX + 1);

  logic [NPH-1:0]  r_fmp;
  state_t          r_state;
  logic [2:0]      r_pred;
  logic            r_ref_vld;
  logic [RW-1:0]   r_run;
  logic [MW-1:0]   r_miss;
  logic [2:0]      r_cnt_rec;
  logic            r_cnt_vld;
  logic            r_lock;
  logic            r_err;
  logic            r_slip;
  logic [ERRW-1:0] r_err_cnt;

  logic            w_legal;
  logic [2:0]      w_cnt;
  logic            w_good_acq;
  logic            w_good_lock;
  logic            w_err_set;
  logic [2:0]      w_realign;

  mpck_word_dec #(.NPH(NPH)) u_dec (
    .i_word  (r_fmp),
    .o_legal (w_legal),
    .o_cnt   (w_cnt)
  );

  assign w_good_lock = w_legal && (w_cnt == r_pred);
  assign w_good_acq  = w_good_lock && r_ref_vld;
  assign w_err_set   = EN && (r_state == ST_LOCK) && !w_good_lock;
  // Illegal sample: advance the prediction instead of trusting a stale decode
  assign w_realign   = w_legal ? (w_cnt + 3'd1) : (r_pred + 3'd1);

  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      r_fmp     <= '0;
      r_state   <= ST_IDLE;
      r_pred    <= '0;
      r_ref_vld <= 1'b0;
      r_run     <= '0;
      r_miss    <= '0;
      r_cnt_rec <= '0;
      r_cnt_vld <= 1'b0;
      r_lock    <= 1'b0;
      r_err     <= 1'b0;
      r_slip    <= 1'b0;
    end else begin
      r_fmp  <= FMP;
      r_err  <= w_err_set;
      r_slip <= w_err_set && w_legal;

      if (r_state == ST_IDLE) begin
        r_cnt_vld <= 1'b0;
      end else begin
        r_cnt_vld <= w_legal;
        if (w_legal) r_cnt_rec <= w_cnt;
      end

      if (!EN) begin
        r_state   <= ST_IDLE;
        r_pred    <= '0;
        r_ref_vld <= 1'b0;
        r_run     <= '0;
        r_miss    <= '0;
        r_lock    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state   <= ST_ACQ;
            r_ref_vld <= 1'b0;
            r_run     <= '0;
            r_miss    <= '0;
          end
          ST_ACQ: begin
            r_pred    <= w_realign;
            r_ref_vld <= w_legal;
            r_miss    <= '0;
            if (r_run == RW'(LOCK_CNT)) begin
              r_state <= ST_LOCK;
              r_lock  <= 1'b1;
              r_run   <= '0;
            end else if (w_good_acq) begin
              r_run <= r_run + 1'b1;
            end else begin
              r_run <= '0;
            end
          end
          ST_LOCK: begin
            if (w_good_lock) begin
              r_pred <= r_pred + 3'd1;
              r_miss <= '0;
            end else if (r_miss == MW'(MISS_MAX - 1)) begin
              // Leaving LOCK: seed ACQ with this sample so re-lock starts at once
              r_state   <= ST_ACQ;
              r_lock    <= 1'b0;
              r_run     <= '0;
              r_miss    <= '0;
              r_ref_vld <= w_legal;
              r_pred    <= w_realign;
            end else begin
              r_pred <= r_pred + 3'd1;
              r_miss <= r_miss + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      r_err_cnt <= '0;
    end else if (ERR_CLR) begin
      r_err_cnt <= '0;
    end else if (w_err_set && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign CNT_REC = r_cnt_rec;
  assign CNT_VLD = r_cnt_vld;
  assign LOCK    = r_lock;
  assign ERR     = r_err;
  assign SLIP    = r_slip;
  assign ERR_CNT = r_err_cnt;

endmodule

// File: tb/tb_mpck_phase_decoder.sv
// Directed bench for mpck_phase_decoder: decode table plus lock/slip/error sequences.
module tb_mpck_phase_decoder;

  logic        clk = 1'b0;
  logic        narst = 1'b1;
  logic        en = 1'b0;
  logic [7:0]  fmp = 8'h00;
  logic        clr16 = 1'b0;
  logic        clr4 = 1'b0;

  logic [2:0]  cnt_rec,  cnt_rec4;
  logic        cnt_vld,  cnt_vld4;
  logic        lock,     lock4;
  logic        err,      err4;
  logic        slip,     slip4;
  logic [15:0] err_cnt;
  logic [3:0]  err_cnt4;

  int nvec = 0;
  int nerr = 0;
  logic [2:0] dc;
  logic [7:0] wtab [0:7] = '{8'hE1, 8'hC3, 8'h87, 8'h0F, 8'h1E, 8'h3C, 8'h78, 8'hF0};

  typedef struct {
    logic [7:0] fmp;
    logic       vld;
    logic [2:0] cnt;
  } vec_t;
  vec_t tbl [13];

  always #5 clk = ~clk;

  mpck_phase_decoder #(.LOCK_CNT(16), .MISS_MAX(4), .ERRW(16)) u_dut (
    .CLK(clk), .NARST(narst), .EN(en), .FMP(fmp), .ERR_CLR(clr16),
    .CNT_REC(cnt_rec), .CNT_VLD(cnt_vld), .LOCK(lock), .ERR(err),
    .SLIP(slip), .ERR_CNT(err_cnt)
  );

  mpck_phase_decoder #(.LOCK_CNT(16), .MISS_MAX(4), .ERRW(4)) u_dut4 (
    .CLK(clk), .NARST(narst), .EN(en), .FMP(fmp), .ERR_CLR(clr4),
    .CNT_REC(cnt_rec4), .CNT_VLD(cnt_vld4), .LOCK(lock4), .ERR(err4),
    .SLIP(slip4), .ERR_CNT(err_cnt4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [7:0] w);
    fmp = w;
    @(posedge clk);
    #1;
  endtask

  task automatic clean();
    cyc(wtab[dc]);
    dc = dc + 3'd1;
  endtask

  task automatic do_acquire(input string tag);
    int rise;
    narst = 1'b1;
    en    = 1'b1;
    dc    = 3'd0;
    clean();
    chk({tag, "_vld_e1"}, cnt_vld, 1'b0);
    clean();
    chk({tag, "_vld_e2"}, cnt_vld, 1'b1);
    chk({tag, "_rec_e2"}, cnt_rec, 3'd0);
    clean();
    chk({tag, "_rec_e3"}, cnt_rec, 3'd1);
    rise = 0;
    for (int n = 4; n <= 40 && rise == 0; n++) begin
      clean();
      if (lock) rise = n;
    end
    chk({tag, "_lock_edge"}, rise, 19);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nbad, npulse, rise;
    logic [2:0] e;

    tbl[0]  = '{8'hE1, 1'b1, 3'd0};
    tbl[1]  = '{8'h0F, 1'b1, 3'd3};
    tbl[2]  = '{8'h00, 1'b0, 3'd3};
    tbl[3]  = '{8'hF0, 1'b1, 3'd7};
    tbl[4]  = '{8'hFF, 1'b0, 3'd7};
    tbl[5]  = '{8'h3C, 1'b1, 3'd5};
    tbl[6]  = '{8'h87, 1'b1, 3'd2};
    tbl[7]  = '{8'hC3, 1'b1, 3'd1};
    tbl[8]  = '{8'h1E, 1'b1, 3'd4};
    tbl[9]  = '{8'h78, 1'b1, 3'd6};
    tbl[10] = '{8'h01, 1'b0, 3'd6};
    tbl[11] = '{8'hE3, 1'b0, 3'd6};
    tbl[12] = '{8'h80, 1'b0, 3'd6};

    // Reset state
    #1 narst = 1'b0;
    cyc(8'h00);
    cyc(8'h00);
    chk("rst_outs", {cnt_rec, cnt_vld, lock, err, slip}, 7'd0);
    chk("rst_errcnt", err_cnt, 16'd0);
    chk("rst_outs4", {cnt_rec4, cnt_vld4, lock4, err4, slip4}, 7'd0);
    chk("rst_errcnt4", err_cnt4, 4'd0);

    // Decode table in ACQ; outputs lag the applied word by two edges
    narst = 1'b1;
    en    = 1'b1;
    cyc(8'h00);
    cyc(8'h00);
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].fmp);
      if (i > 0)
        chk($sformatf("tbl_%0d", i - 1), {cnt_vld, cnt_rec, lock, err, slip},
            {tbl[i-1].vld, tbl[i-1].cnt, 3'b000});
    end
    cyc(tbl[12].fmp);
    chk("tbl_12", {cnt_vld, cnt_rec, lock, err, slip}, {tbl[12].vld, tbl[12].cnt, 3'b000});

    // EN drop: state to IDLE at the next edge, CNT_VLD clears one edge later
    en = 1'b0;
    cyc(8'hE1);
    cyc(8'hE1);
    chk("en_drop_vld_lock", {cnt_vld, lock}, 2'b00);

    // Clean acquisition from reset
    #2 narst = 1'b0;
    cyc(8'h00);
    do_acquire("acq1");
    nbad = 0;
    for (int n = 0; n < 1000; n++) begin
      e = dc - 3'd1;
      clean();
      if (err || slip || !lock || !cnt_vld || cnt_rec != e) nbad++;
    end
    chk("clean_bad_cycles", nbad, 0);
    chk("clean_errcnt", err_cnt, 16'd0);

    // Single corrupt cycle while locked
    cyc(8'h00); dc = dc + 3'd1;
    clean();
    chk("corrupt_err_slip_vld", {err, slip, cnt_vld}, 3'b100);
    chk("corrupt_errcnt", err_cnt, 16'd1);
    chk("corrupt_lock", lock, 1'b1);
    clean();
    chk("corrupt_after", {err, cnt_vld}, 2'b01);
    for (int n = 0; n < 5; n++) clean();
    chk("corrupt_lock_held", lock, 1'b1);

    // ERR_CLR alone
    clr16 = 1'b1; clr4 = 1'b1;
    clean();
    clr16 = 1'b0; clr4 = 1'b0;
    chk("clr_errcnt", err_cnt, 16'd0);

    // Divider skips 3 -> 5
    for (int n = 0; n < 8 && dc != 3'd4; n++) clean();
    dc = 3'd5;
    clean();
    npulse = 0;
    for (int i = 1; i <= 4; i++) begin
      clean();
      if (err && slip) npulse++;
      if (i == 3) chk("skip_lock_i3", lock, 1'b1);
      if (i == 4) chk("skip_lock_i4", lock, 1'b0);
    end
    chk("skip_pulses", npulse, 4);
    chk("skip_errcnt", err_cnt, 16'd4);
    rise = 0; nbad = 0;
    for (int i = 1; i <= 40 && rise == 0; i++) begin
      clean();
      if (err || slip) nbad++;
      if (lock) rise = i;
    end
    chk("skip_relock_cycles", rise, 17);
    chk("skip_relock_noerr", nbad, 0);

    // Continuous 0xFF while locked
    cyc(8'hFF);
    npulse = 0; nbad = 0;
    for (int i = 1; i <= 24; i++) begin
      cyc(8'hFF);
      if (err) npulse++;
      if (i == 3) chk("ff_lock_i3", lock, 1'b1);
      if (i == 4) chk("ff_lock_i4", lock, 1'b0);
      if (i > 4 && (err || cnt_vld || lock)) nbad++;
    end
    chk("ff_err_pulses", npulse, 4);
    chk("ff_quiet_acq", nbad, 0);

    // Re-lock, then saturate the 4-bit counter
    rise = 0;
    for (int i = 1; i <= 40 && rise == 0; i++) begin
      clean();
      if (lock) rise = i;
    end
    chk("ff_relock", rise != 0, 1'b1);
    clr16 = 1'b1; clr4 = 1'b1;
    clean();
    clr16 = 1'b0; clr4 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc(8'h00); dc = dc + 3'd1;
      clean(); clean(); clean();
    end
    chk("sat_errcnt4", err_cnt4, 4'd15);
    chk("sat_errcnt16", err_cnt, 16'd20);
    chk("sat_lock", {lock, lock4}, 2'b11);

    // ERR_CLR at the same edge an error is counted
    cyc(8'h00); dc = dc + 3'd1;
    clr16 = 1'b1; clr4 = 1'b1;
    clean();
    clr16 = 1'b0; clr4 = 1'b0;
    chk("clr_coinc_err", {err, err4}, 2'b11);
    chk("clr_coinc_cnt4", err_cnt4, 4'd0);
    chk("clr_coinc_cnt16", err_cnt, 16'd0);
    clean();
    chk("clr_coinc_after", err_cnt4, 4'd0);

    // Asynchronous reset mid-LOCK
    cyc(8'h00); dc = dc + 3'd1;
    clean(); clean();
    chk("prerst_errcnt", err_cnt, 16'd1);
    #2 narst = 1'b0;
    #1;
    chk("midrst_outs", {cnt_rec, cnt_vld, lock, err, slip}, 7'd0);
    chk("midrst_errcnt", err_cnt, 16'd0);
    chk("midrst_errcnt4", err_cnt4, 4'd0);
    cyc(8'h00);
    cyc(8'h00);
    do_acquire("acq2");
    for (int n = 0; n < 8; n++) clean();
    chk("acq2_errcnt", err_cnt, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
